coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

N-core coherent memory bus controller that sits between `CPUS` private L1 cache pairs and the single shared RAM. It arbitrates instruction fetches, plain data writebacks and coherent BusRd/BusRdX transactions. Coherent requests snoop every other core and use cache-to-cache (C2C) transfer with simultaneous RAM writeback; a configurable snoop timeout falls back to a RAM fetch. It generalises the two-core controller to any core count and adds round-robin fairness.

## Interface
- `CPUS`, default 2: number of cores, 2..8.
- `SNOOP_TIMEOUT`, default 2: cycles to wait for a snoop response before fetching from RAM; legal range 1..15.
- `CLK`  in  1  clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`, `dREN`, `dWEN`, `cctrans`, `ccwrite`  in  CPUS each  per-core requests; `cctrans & ccwrite` = BusRdX.
- `iaddr`, `daddr`, `dstore`  in  CPUS x word_t  per-core addresses and write data.
- `iwait`, `dwait`  out  CPUS each  low for exactly the cycle a word is served.
- `iload`, `dload`  out  CPUS x word_t  read data.
- `ccwait`, `ccinv`  out  CPUS each  snoop hold and invalidate, per core.
- `ccsnoopaddr`  out  CPUS x word_t  snoop address, per core.
- `ramaddr`, `ramstore`  out  word_t  RAM address and write data.
- `ramWEN`, `ramREN`  out  1 each  RAM write and read enables.
- `ramload`  in  word_t  RAM read data.
- `ramstate`  in  ramstate_t  RAM status; ACCESS marks a completed word.

## Operation
- Output defaults apply every cycle unless overridden, and hold during reset: `iwait`/`dwait` all 1; `ccwait`, `ccinv`, `ramWEN`, `ramREN` all 0; all address, data and load outputs 0.
- Registered state: `state`, `req` (requester index), `resp` (responder index), `tmo` counter, `rr_d` and `rr_i` round-robin pointers. All reset to IDLE or 0.
- **IDLE**, requests are served in this priority order:
  - Plain writeback, i.e. some core has `dWEN & !cctrans` (round-robin over `rr_d`): drive that core's `daddr`/`dstore` to RAM with `ramWEN`=1. `dwait`=0 on ACCESS. Stay in IDLE.
  - Any `cctrans`: latch winner into `req` (round-robin from `rr_d`), go to SNOOP.
  - Any `iREN` (round-robin over `rr_i`): `ramREN`=1, `ramaddr`=`iaddr`, `iload`=`ramload`, `iwait`=0 on ACCESS. `rr_i` advances to winner+1 on ACCESS.
- **SNOOP** (1 cycle). For every core k≠`req`, through the end of the transaction:
  - `ccwait[k]`=1.
  - `ccsnoopaddr[k]`=`daddr[req]`.
  - `ccinv[k]`=`ccwrite[req]`.
  - Clear `tmo`, go to SNOOP_WAIT.
- **SNOOP_WAIT**:
  - If some k≠`req` asserts `dWEN` (lowest index wins), latch `resp`, go to C2C.
  - Otherwise `tmo`++. When `tmo`==`SNOOP_TIMEOUT`-1, go to FETCH.
- **C2C**: `ramWEN`=1, `ramaddr`=`daddr[resp]`, `ramstore`=`dstore[resp]`, `dload[req]`=`dstore[resp]`. On ACCESS, `dwait[resp]`=0 and `dwait[req]`=0 in the same cycle. Stay while `dWEN[resp]`=1; otherwise go to FETCH.
- **FETCH**:
  - While `dREN[req]`: `ramREN`=1, `ramaddr`=`daddr[req]`, `dload[req]`=`ramload`, `dwait[req]`=0 on ACCESS.
  - While `dWEN[req]`: write `dstore[req]` to RAM the same way.
  - When `cctrans[req]`=0, go to IDLE and set `rr_d` to `req`+1 mod CPUS.
- `iwait` stays 1 for all cores outside IDLE.
- Round-robin: grant the lowest index ≥ pointer with a request, wrapping to 0.

## Timing
- Minimum coherent latency (no responder, RAM ACCESS on the first cycle): IDLE→SNOOP→SNOOP_WAIT×`SNOOP_TIMEOUT`→FETCH, so the first word arrives in cycle 2+`SNOOP_TIMEOUT`.
- C2C word latency equals RAM write latency. The requester never waits for a separate RAM read.
- Simultaneous `cctrans` from several cores: exactly one is granted. The others see `ccwait`=1 and must hold their requests.
- Two responders asserting `dWEN` in the same cycle is a protocol error; the lowest index is taken.
- A requester dropping `cctrans` in SNOOP_WAIT goes straight to IDLE without a RAM access.
- Reset asserted mid-transaction: state returns to IDLE immediately and all outputs take their defaults in the same cycle.

## Structure
- In `cpu_types_pkg`: `cohr_state_t` (IDLE, SNOOP, SNOOP_WAIT, C2C, FETCH) and `CPUID_W = $clog2(CPUS)`.
- Sub-module `rr_arbiter`: parameter `N`; ports `req[N]` and `ptr`; outputs `grant_idx` and `grant_valid`. It is purely combinational and is instanced twice (data/coherent and instruction). The pointer registers stay in the parent.

## Test plan
- CPUS=4: `iREN`=4'b1111 held, RAM ACCESS every cycle → served in order 0,1,2,3,0. No core is starved.
- Core 2 BusRd to 0x100, no responder, `SNOOP_TIMEOUT`=2 → `ccwait`=4'b1011, `ccsnoopaddr[0/1/3]`=0x100, `ccinv`=0. FETCH begins in cycle 4, `dload[2]`=`ramload`.
- Core 0 BusRdX to 0x200; core 3 responds with 2 words 0xA, 0xB → `ccinv`=4'b1110. `ramWEN` writes 0xA then 0xB; `dload[0]` = 0xA then 0xB. `dwait[0]` and `dwait[3]` are both low on each ACCESS.
- Plain `dWEN[1]` and `cctrans[2]` in the same IDLE cycle → the writeback is served first, then SNOOP for core 2.
- Simultaneous `cctrans` from cores 1 and 3 with `rr_d`=2 → core 3 is granted first; core 1 follows and `rr_d` ends at 2.
- `nRST` pulsed during C2C → the same cycle shows state IDLE, `ramWEN`=0 and `dwait`=all 1; the next `cctrans` restarts cleanly.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM status and coherence state types
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE,
      SNOOP,
      SNOOP_WAIT,
      C2C,
      FETCH
   } cohr_state_t;

   // width of a core index: CPUID_W = $clog2(CPUS)
   function automatic int cpuid_w(input int cpus);
      return (cpus > 1) ? $clog2(cpus) : 1;
   endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// rtl/coherence_bus_ctrl_rr_arbiter.sv - combinational round-robin pick from a pointer
module rr_arbiter #(
   parameter int N = 2,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant_idx,
   output logic         grant_valid
);

   // scan from the farthest offset back to ptr so the nearest requester is written last
   always_comb begin
      logic [W-1:0] idx;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int off = N - 1; off >= 0; off--) begin
         idx = W'((int'(ptr) + off) % N);
         if (req[idx]) begin
            grant_idx   = idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - N-core snooping bus controller with C2C transfer and RAM fallback
module coherence_bus_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CPUS          = 2,
   parameter int SNOOP_TIMEOUT = 2
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic      [CPUS-1:0] iREN,
   input  logic      [CPUS-1:0] dREN,
   input  logic      [CPUS-1:0] dWEN,
   input  logic      [CPUS-1:0] cctrans,
   input  logic      [CPUS-1:0] ccwrite,
   input  word_t     [CPUS-1:0] iaddr,
   input  word_t     [CPUS-1:0] daddr,
   input  word_t     [CPUS-1:0] dstore,
   output logic      [CPUS-1:0] iwait,
   output logic      [CPUS-1:0] dwait,
   output word_t     [CPUS-1:0] iload,
   output word_t     [CPUS-1:0] dload,
   output logic      [CPUS-1:0] ccwait,
   output logic      [CPUS-1:0] ccinv,
   output word_t     [CPUS-1:0] ccsnoopaddr,
   output word_t                ramaddr,
   output word_t                ramstore,
   output logic                 ramWEN,
   output logic                 ramREN,
   input  word_t                ramload,
   input  ramstate_t            ramstate
);

   localparam int CPUID_W = cpuid_w(CPUS);
   localparam logic [3:0] TMO_LAST = 4'(SNOOP_TIMEOUT - 1);

   typedef logic [CPUID_W-1:0] cpuid_t;

   cohr_state_t state, state_n;
   cpuid_t      req, req_n;
   cpuid_t      resp, resp_n;
   cpuid_t      rr_d, rr_d_n;
   cpuid_t      rr_i, rr_i_n;
   logic [3:0]  tmo, tmo_n;

   logic [CPUS-1:0] wb_req;
   logic [CPUS-1:0] d_arb_req;
   cpuid_t          d_gidx, i_gidx;
   logic            d_gvalid, i_gvalid;
   cpuid_t          resp_idx;
   logic            resp_hit;
   logic            acc;

   function automatic cpuid_t next_core(input cpuid_t i);
      return (int'(i) == CPUS - 1) ? '0 : cpuid_t'(i + 1'b1);
   endfunction

   // plain writebacks outrank coherent requests, so the data arbiter sees them first
   assign wb_req    = dWEN & ~cctrans;
   assign d_arb_req = (|wb_req) ? wb_req : cctrans;
   assign acc       = (ramstate == ACCESS);

   rr_arbiter #(.N(CPUS), .W(CPUID_W)) u_d_arb (
      .req         (d_arb_req),
      .ptr         (rr_d),
      .grant_idx   (d_gidx),
      .grant_valid (d_gvalid)
   );

   rr_arbiter #(.N(CPUS), .W(CPUID_W)) u_i_arb (
      .req         (iREN),
      .ptr         (rr_i),
      .grant_idx   (i_gidx),
      .grant_valid (i_gvalid)
   );

   // lowest-index snooped core raising dWEN becomes the responder
   always_comb begin
      resp_idx = '0;
      resp_hit = 1'b0;
      for (int k = CPUS - 1; k >= 0; k--) begin
         if (dWEN[k] && (cpuid_t'(k) != req)) begin
            resp_idx = cpuid_t'(k);
            resp_hit = 1'b1;
         end
      end
   end

   // state and pointer registers, cleared asynchronously
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         req   <= '0;
         resp  <= '0;
         tmo   <= '0;
         rr_d  <= '0;
         rr_i  <= '0;
      end else begin
         state <= state_n;
         req   <= req_n;
         resp  <= resp_n;
         tmo   <= tmo_n;
         rr_d  <= rr_d_n;
         rr_i  <= rr_i_n;
      end
   end

   // next state and bus outputs; everything holds its default while reset is low
   always_comb begin
      state_n     = state;
      req_n       = req;
      resp_n      = resp;
      tmo_n       = tmo;
      rr_d_n      = rr_d;
      rr_i_n      = rr_i;
      iwait       = '1;
      dwait       = '1;
      iload       = '0;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramaddr     = '0;
      ramstore    = '0;
      ramWEN      = 1'b0;
      ramREN      = 1'b0;

      if (nRST) begin
         if (state != IDLE) begin
            for (int k = 0; k < CPUS; k++) begin
               if (cpuid_t'(k) != req) begin
                  ccwait[k]      = 1'b1;
                  ccsnoopaddr[k] = daddr[req];
                  ccinv[k]       = ccwrite[req];
               end
            end
         end

         case (state)
            IDLE: begin
               if (|wb_req) begin
                  ramWEN   = 1'b1;
                  ramaddr  = daddr[d_gidx];
                  ramstore = dstore[d_gidx];
                  if (acc) dwait[d_gidx] = 1'b0;
               end else if (d_gvalid) begin
                  req_n   = d_gidx;
                  state_n = SNOOP;
               end else if (i_gvalid) begin
                  ramREN         = 1'b1;
                  ramaddr        = iaddr[i_gidx];
                  iload[i_gidx]  = ramload;
                  if (acc) begin
                     iwait[i_gidx] = 1'b0;
                     rr_i_n        = next_core(i_gidx);
                  end
               end
            end
            SNOOP: begin
               tmo_n   = '0;
               state_n = SNOOP_WAIT;
            end
            SNOOP_WAIT: begin
               if (!cctrans[req]) begin
                  state_n = IDLE;
                  rr_d_n  = next_core(req);
               end else if (resp_hit) begin
                  resp_n  = resp_idx;
                  state_n = C2C;
               end else if (tmo == TMO_LAST) begin
                  state_n = FETCH;
               end else begin
                  tmo_n = tmo + 4'd1;
               end
            end
            C2C: begin
               // the RAM writeback and the requester's load share the same word
               if (dWEN[resp]) begin
                  ramWEN     = 1'b1;
                  ramaddr    = daddr[resp];
                  ramstore   = dstore[resp];
                  dload[req] = dstore[resp];
                  if (acc) begin
                     dwait[resp] = 1'b0;
                     dwait[req]  = 1'b0;
                  end
               end else begin
                  state_n = FETCH;
               end
            end
            FETCH: begin
               if (dREN[req]) begin
                  ramREN     = 1'b1;
                  ramaddr    = daddr[req];
                  dload[req] = ramload;
                  if (acc) dwait[req] = 1'b0;
               end else if (dWEN[req]) begin
                  ramWEN   = 1'b1;
                  ramaddr  = daddr[req];
                  ramstore = dstore[req];
                  if (acc) dwait[req] = 1'b0;
               end
               if (!cctrans[req]) begin
                  state_n = IDLE;
                  rr_d_n  = next_core(req);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - directed and random checks of coherence_bus_ctrl against a transaction model
module tb_coherence_bus_ctrl;
   import cpu_types_pkg::*;

   localparam int N = 4;
   localparam int T = 2;

   logic            CLK = 1'b0;
   logic            nRST;
   logic [N-1:0]    iREN, dREN, dWEN, cctrans, ccwrite;
   word_t [N-1:0]   iaddr, daddr, dstore;
   logic [N-1:0]    iwait, dwait, ccwait, ccinv;
   word_t [N-1:0]   iload, dload, ccsnoopaddr;
   word_t           ramaddr, ramstore, ramload;
   logic            ramWEN, ramREN;
   ramstate_t       ramstate;

   int n_chk = 0;
   int n_err = 0;

   // model: transaction in flight, its owner, cycles since grant, responder, fetch phase, pointers
   bit m_act = 0, n_act;
   int m_req = 0, n_req;
   int m_age = 0, n_age;
   int m_resp = -1, n_resp;
   bit m_fetch = 0, n_fetch;
   int m_rrd = 0, n_rrd;
   int m_rri = 0, n_rri;

   logic [N-1:0]  e_iwait, e_dwait, e_ccwait, e_ccinv;
   word_t [N-1:0] e_iload, e_dload, e_snoop;
   word_t         e_ramaddr, e_ramstore;
   logic          e_ramWEN, e_ramREN;

   coherence_bus_ctrl #(.CPUS(N), .SNOOP_TIMEOUT(T)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramWEN(ramWEN), .ramREN(ramREN),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int o = 0; o < N; o++) begin
         int c;
         c = (ptr + o) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_eval();
      int g, r;
      bit acc;
      acc = (ramstate == ACCESS);
      e_iwait = '1; e_dwait = '1; e_ccwait = '0; e_ccinv = '0;
      e_iload = '0; e_dload = '0; e_snoop = '0;
      e_ramaddr = '0; e_ramstore = '0; e_ramWEN = 0; e_ramREN = 0;
      n_act = m_act; n_req = m_req; n_age = m_age; n_resp = m_resp;
      n_fetch = m_fetch; n_rrd = m_rrd; n_rri = m_rri;
      if (!nRST) begin
         n_act = 0; n_req = 0; n_age = 0; n_resp = -1; n_fetch = 0; n_rrd = 0; n_rri = 0;
      end else if (!m_act) begin
         g = pick(dWEN & ~cctrans, m_rrd);
         if (g >= 0) begin
            e_ramWEN = 1; e_ramaddr = daddr[g]; e_ramstore = dstore[g];
            if (acc) e_dwait[g] = 0;
         end else begin
            g = pick(cctrans, m_rrd);
            if (g >= 0) begin
               n_act = 1; n_req = g; n_age = 0; n_resp = -1; n_fetch = 0;
            end else begin
               g = pick(iREN, m_rri);
               if (g >= 0) begin
                  e_ramREN = 1; e_ramaddr = iaddr[g]; e_iload[g] = ramload;
                  if (acc) begin e_iwait[g] = 0; n_rri = (g + 1) % N; end
               end
            end
         end
      end else begin
         for (int k = 0; k < N; k++)
            if (k != m_req) begin
               e_ccwait[k] = 1; e_snoop[k] = daddr[m_req]; e_ccinv[k] = ccwrite[m_req];
            end
         if (m_resp >= 0) begin
            if (dWEN[m_resp]) begin
               e_ramWEN = 1; e_ramaddr = daddr[m_resp]; e_ramstore = dstore[m_resp];
               e_dload[m_req] = dstore[m_resp];
               if (acc) begin e_dwait[m_resp] = 0; e_dwait[m_req] = 0; end
            end else begin
               n_resp = -1; n_fetch = 1;
            end
         end else if (m_fetch) begin
            if (dREN[m_req]) begin
               e_ramREN = 1; e_ramaddr = daddr[m_req]; e_dload[m_req] = ramload;
               if (acc) e_dwait[m_req] = 0;
            end else if (dWEN[m_req]) begin
               e_ramWEN = 1; e_ramaddr = daddr[m_req]; e_ramstore = dstore[m_req];
               if (acc) e_dwait[m_req] = 0;
            end
            if (!cctrans[m_req]) begin n_act = 0; n_rrd = (m_req + 1) % N; end
         end else if (m_age == 0) begin
            n_age = 1;
         end else begin
            r = -1;
            for (int k = 0; k < N; k++)
               if (r < 0 && k != m_req && dWEN[k]) r = k;
            if (!cctrans[m_req]) begin n_act = 0; n_rrd = (m_req + 1) % N; end
            else if (r >= 0) n_resp = r;
            else if (m_age == T) n_fetch = 1;
            else n_age = m_age + 1;
         end
      end
   endtask

   task automatic settle();
      @(negedge CLK);
      model_eval();
      chk("iwait", iwait, e_iwait);
      chk("dwait", dwait, e_dwait);
      chk("ccwait", ccwait, e_ccwait);
      chk("ccinv", ccinv, e_ccinv);
      chk("ccsnoopaddr", ccsnoopaddr, e_snoop);
      chk("iload", iload, e_iload);
      chk("dload", dload, e_dload);
      chk("ramaddr", ramaddr, e_ramaddr);
      chk("ramstore", ramstore, e_ramstore);
      chk("ramWEN", ramWEN, e_ramWEN);
      chk("ramREN", ramREN, e_ramREN);
   endtask

   task automatic adv();
      m_act = n_act; m_req = n_req; m_age = n_age; m_resp = n_resp;
      m_fetch = n_fetch; m_rrd = n_rrd; m_rri = n_rri;
      @(posedge CLK);
      #1;
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin settle(); adv(); end
   endtask

   task automatic clear_inputs();
      iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = ACCESS;
   endtask

   task automatic rand_inputs();
      logic [N-1:0] m;
      m = N'($urandom & $urandom); cctrans = cctrans ^ m;
      m = N'($urandom & $urandom); dREN = dREN ^ m;
      m = N'($urandom & $urandom); dWEN = dWEN ^ m;
      m = N'($urandom & $urandom); ccwrite = ccwrite ^ m;
      iREN = N'($urandom);
      for (int k = 0; k < N; k++) begin
         iaddr[k] = $urandom; daddr[k] = $urandom; dstore[k] = $urandom;
      end
      ramload = $urandom;
      case ($urandom_range(0, 3))
         0: ramstate = FREE;
         1: ramstate = BUSY;
         default: ramstate = ACCESS;
      endcase
      nRST = ($urandom_range(0, 199) != 0);
   endtask

   initial begin
      int seq [5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] ex;

      nRST = 1'b0;
      clear_inputs();
      iREN = '1;
      settle();
      chk("rst_iwait", iwait, 4'hF);
      chk("rst_dwait", dwait, 4'hF);
      chk("rst_ramREN", ramREN, 1'b0);
      adv();
      nRST = 1'b1;

      // instruction fetch fairness: 0,1,2,3,0
      for (int i = 0; i < 5; i++) begin
         settle();
         ex = ~(4'b0001 << seq[i]);
         chk("iorder", iwait, ex);
         adv();
      end
      clear_inputs();

      // core 2 BusRd to 0x100, nobody answers
      cctrans = 4'b0100; dREN = 4'b0100; daddr[2] = 32'h100; ramload = 32'hDEAD;
      step();
      settle();
      chk("b_ccwait", ccwait, 4'b1011);
      chk("b_ccinv", ccinv, 4'b0000);
      chk("b_snoop0", ccsnoopaddr[0], 32'h100);
      chk("b_snoop3", ccsnoopaddr[3], 32'h100);
      adv();
      step(2);
      settle();
      chk("b_ramREN", ramREN, 1'b1);
      chk("b_ramaddr", ramaddr, 32'h100);
      chk("b_dload2", dload[2], 32'hDEAD);
      chk("b_dwait", dwait, 4'b1011);
      adv();
      clear_inputs();
      step();

      // core 0 BusRdX to 0x200, core 3 supplies 0xA then 0xB
      cctrans = 4'b0001; ccwrite = 4'b0001; dREN = 4'b0001; daddr[0] = 32'h200;
      step();
      settle();
      chk("c_ccinv", ccinv, 4'b1110);
      adv();
      dWEN = 4'b1000; daddr[3] = 32'h200; dstore[3] = 32'hA;
      step();
      for (int w = 0; w < 2; w++) begin
         dstore[3] = (w == 0) ? 32'hA : 32'hB;
         settle();
         chk("c_ramWEN", ramWEN, 1'b1);
         chk("c_ramstore", ramstore, (w == 0) ? 32'hA : 32'hB);
         chk("c_dload0", dload[0], (w == 0) ? 32'hA : 32'hB);
         chk("c_dwait", dwait, 4'b0110);
         adv();
      end
      clear_inputs();
      step(2);

      // writeback from core 1 beats coherent request from core 2
      dWEN = 4'b0010; daddr[1] = 32'h300; dstore[1] = 32'h55;
      cctrans = 4'b0100; daddr[2] = 32'h400;
      settle();
      chk("d_ramWEN", ramWEN, 1'b1);
      chk("d_ramaddr", ramaddr, 32'h300);
      chk("d_dwait", dwait, 4'b1101);
      adv();
      dWEN = '0;
      step();
      settle();
      chk("d_ccwait", ccwait, 4'b1011);
      adv();
      cctrans = '0;
      step(2);

      // bring rr_d to 2 with a short core-1 transaction, then contend 1 vs 3
      cctrans = 4'b0010;
      step();
      cctrans = '0;
      step(2);
      cctrans = 4'b1010;
      step();
      settle();
      chk("e_first3", ccwait, 4'b0111);
      adv();
      cctrans = 4'b0010;
      step(2);
      settle();
      chk("e_then1", ccwait, 4'b1101);
      adv();
      cctrans = '0;
      step();
      cctrans = 4'b1010;
      step();
      settle();
      chk("e_rrd2", ccwait, 4'b0111);
      adv();
      cctrans = '0;
      step();

      // reset pulse during C2C
      cctrans = 4'b0001; dREN = 4'b0001; daddr[0] = 32'h40;
      step(2);
      dWEN = 4'b1000; dstore[3] = 32'h77;
      step();
      settle();
      chk("f_c2c", ramWEN, 1'b1);
      adv();
      nRST = 1'b0;
      settle();
      chk("f_ramWEN", ramWEN, 1'b0);
      chk("f_dwait", dwait, 4'hF);
      chk("f_ccwait", ccwait, 4'h0);
      adv();
      nRST = 1'b1;
      clear_inputs();
      step();
      cctrans = 4'b0100;
      step();
      settle();
      chk("f_restart", ccwait, 4'b1011);
      adv();
      clear_inputs();
      step(2);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
